// File: rtl/i2c_diag_pkg.sv
// i2c_diag_pkg: shared address, frame size, FSM encoding and frame byte selector for i2c_diag_target
package i2c_diag_pkg;
  localparam logic [6:0] I2C_DIAG_ADDR = 7'h5D;
  localparam int FRAME_BYTES = 3;
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE, READ, READ_ACK} state_t;
  function automatic logic [7:0] frame_byte(input logic [23:0] f, input logic [1:0] i);
    return (i == 2'd0) ? f[23:16] : (i == 2'd1) ? f[15:8] : f[7:0];
  endfunction
endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: 2-FF synchronizer, FILT_LEN-sample stability filter and edge strobes for one I2C line
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic resetn,
  input  logic line,
  output logic filt,
  output logic rise,
  output logic fall
);
  logic [1:0] sync;
  logic [FILT_LEN-1:0] hist;
  logic prev;
  // Synchronize, then move the filtered level only once the whole history agrees
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync <= 2'b11;
      hist <= '1;
      filt <= 1'b1;
      prev <= 1'b1;
    end else begin
      sync <= {sync[0], line};
      hist <= FILT_LEN'({hist, sync[1]});
      filt <= (&hist) ? 1'b1 : (~|hist) ? 1'b0 : filt;
      prev <= filt;
    end
  end
  assign rise = filt && !prev;
  assign fall = !filt && prev;
endmodule

// File: rtl/i2c_diag_target.sv
// i2c_diag_target: I2C target decoding page/value diagnostic frames; I2C_DIAG_TGT_READBACK_EN adds frame readback
module i2c_diag_target
  import i2c_diag_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR   = I2C_DIAG_ADDR,
  parameter int         FILT_LEN   = 3,
  parameter bit         STRETCH_EN = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        scl,
  inout  wire         sda,
  output logic        frame_valid,
  output logic [7:0]  frame_page,
  output logic [15:0] frame_value,
  output logic        err_short,
  output logic        busy
);
  localparam logic [1:0] LAST = 2'(FRAME_BYTES);
  state_t state, state_n;
  logic scl_f, scl_rise, scl_fall, sda_f, sda_rise, sda_fall;
  logic start, stop, byte_done, addr_hit, addr_ok, wr_act;
  logic [3:0] bit_cnt;
  logic [1:0] byte_cnt;
  logic [7:0] shreg;
  logic [7:0] stage [FRAME_BYTES];
  logic rd, sda_oe, sda_oe_n;
`ifdef I2C_DIAG_TGT_READBACK_EN
  logic [23:0] snap;
  logic [7:0] tx, nxt_byte;
  logic [1:0] rd_idx, nxt_idx;
  logic mack;
`endif

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl (.clk(clk), .resetn(resetn), .line(scl), .filt(scl_f), .rise(scl_rise), .fall(scl_fall));
  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda (.clk(clk), .resetn(resetn), .line(sda), .filt(sda_f), .rise(sda_rise), .fall(sda_fall));

  assign start = sda_fall && scl_f;
  assign stop = sda_rise && scl_f;
  assign byte_done = scl_fall && bit_cnt == 4'd8;
  assign addr_hit = shreg[7:1] == I2C_ADDR;
`ifdef I2C_DIAG_TGT_READBACK_EN
  assign addr_ok = addr_hit;
  assign nxt_idx = (rd_idx == 2'd2) ? 2'd0 : rd_idx + 2'd1;
  assign nxt_byte = frame_byte(snap, nxt_idx);
`else
  assign addr_ok = addr_hit && !shreg[0];
`endif
  assign wr_act = !rd && (state == ADDR_ACK || state == DATA || state == DATA_ACK);
  assign busy = state inside {ADDR_ACK, DATA, DATA_ACK, READ, READ_ACK};
  assign sda = (sda_oe && !STRETCH_EN) ? 1'b0 : 1'bz;

  // State and SDA drive register; reset releases SDA at once
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      sda_oe <= 1'b0;
    end else begin
      state <= state_n;
      sda_oe <= sda_oe_n;
    end
  end

  // Next state and SDA drive: START/STOP win from any state, ACK slots open and close on SCL falls
  always_comb begin
    state_n = state;
    sda_oe_n = sda_oe;
    if (start || stop) begin
      state_n = start ? ADDR : IDLE;
      sda_oe_n = 1'b0;
    end else begin
      case (state)
        ADDR: if (byte_done) begin
          state_n = addr_ok ? ADDR_ACK : IGNORE;
          sda_oe_n = addr_ok;
        end
        ADDR_ACK: if (scl_fall) begin
`ifdef I2C_DIAG_TGT_READBACK_EN
          state_n = rd ? READ : DATA;
          sda_oe_n = rd && !snap[23];
`else
          state_n = DATA;
          sda_oe_n = 1'b0;
`endif
        end
        DATA: if (byte_done) begin
          state_n = DATA_ACK;
          sda_oe_n = byte_cnt != LAST;
        end
        DATA_ACK: if (scl_fall) begin
          state_n = DATA;
          sda_oe_n = 1'b0;
        end
`ifdef I2C_DIAG_TGT_READBACK_EN
        READ: if (scl_fall) begin
          state_n = byte_done ? READ_ACK : READ;
          sda_oe_n = !byte_done && !tx[7];
        end
        READ_ACK: if (scl_fall) begin
          state_n = mack ? READ : IGNORE;
          sda_oe_n = mack && !nxt_byte[7];
        end
`endif
        default: ;
      endcase
    end
  end

  // Bit/byte counting, staging capture and frame/error output pulses
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bit_cnt <= 4'd0;
      byte_cnt <= 2'd0;
      shreg <= 8'd0;
      rd <= 1'b0;
      stage <= '{default: '0};
      frame_valid <= 1'b0;
      frame_page <= 8'd0;
      frame_value <= 16'd0;
      err_short <= 1'b0;
    end else begin
      frame_valid <= stop && wr_act && byte_cnt == LAST;
      err_short <= (start || stop) && wr_act && byte_cnt != LAST;
      if (stop && wr_act && byte_cnt == LAST) begin
        frame_page <= stage[0];
        frame_value <= {stage[1], stage[2]};
      end
      if (start) begin
        bit_cnt <= 4'd0;
        byte_cnt <= 2'd0;
      end else if (scl_rise && bit_cnt != 4'd8 && (state == ADDR || state == DATA || state == READ)) begin
        shreg <= {shreg[6:0], sda_f};
        bit_cnt <= bit_cnt + 4'd1;
      end else if (scl_fall && (state == ADDR_ACK || state == DATA_ACK || state == READ_ACK)) begin
        bit_cnt <= 4'd0;
      end
      if (byte_done && state == ADDR) rd <= shreg[0];
      if (byte_done && state == DATA && byte_cnt != LAST) begin
        stage[byte_cnt] <= shreg;
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end

`ifdef I2C_DIAG_TGT_READBACK_EN
  // Readback: snapshot the last frame at address match, shift bytes out MSB first, index wraps 2->0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      snap <= 24'd0;
      tx <= 8'd0;
      rd_idx <= 2'd0;
      mack <= 1'b0;
    end else begin
      if (byte_done && state == ADDR && addr_hit && shreg[0]) snap <= {frame_page, frame_value};
      if (scl_fall && state == ADDR_ACK) begin
        tx <= snap[23:16];
        rd_idx <= 2'd0;
      end else if (scl_rise && state == READ) begin
        tx <= {tx[6:0], 1'b0};
      end else if (scl_rise && state == READ_ACK) begin
        mack <= !sda_f;
      end else if (scl_fall && state == READ_ACK && mack) begin
        tx <= nxt_byte;
        rd_idx <= nxt_idx;
      end
    end
  end
`endif
endmodule
